// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - StrataFlash command codes, status bits and sequencer state types
//
// Purpose : shared constants and types for flash_cmd_seq and flash_bus_cycle.
// Contents: CMD_* bus command bytes, SR_* status register bit indices,
//           seq_state_t (command sequencer), bus_state_t (bus-cycle primitive),
//           sr_failed() helper that folds the status error bits.

package flash_pkg;

    localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;
    localparam logic [7:0] CMD_PROGRAM    = 8'h40;
    localparam logic [7:0] CMD_CLR_STATUS = 8'h50;

    localparam int SR_READY    = 7;
    localparam int SR_PROG_ERR = 4;
    localparam int SR_VPP_ERR  = 3;
    localparam int SR_LOCK_ERR = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_FF,
        ST_R_DATA,
        ST_W_40,
        ST_W_DATA,
        ST_R_STAT,
        ST_W_50,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACTIVE,
        BUS_GAP
    } bus_state_t;

    // Any of program, Vpp or block-lock failure reported by a ready status byte.
    function automatic logic sr_failed(input logic [7:0] status);
        return status[SR_PROG_ERR] | status[SR_VPP_ERR] | status[SR_LOCK_ERR];
    endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// rtl/flash_bus_cycle.sv - single flash bridge bus cycle followed by an idle gap
//
// Purpose : runs one bridge transaction per request and enforces GAP_CYCLES
//           idle cycles (fb_start low) after every completed transaction.
// Ports   : i_clk, i_rst        clock, synchronous active-high reset
//           i_req               one-cycle request; i_addr/i_data/i_dir sampled with it
//           o_done              bridge completion of the active cycle (combinational)
//           o_fb_addr/o_fb_data/o_fb_dir/o_fb_start  bridge drive, held while active
//           i_fb_done           bridge completion input

module flash_bus_cycle
    import flash_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_dir,
    output logic       o_done,
    output logic [7:0] o_fb_addr,
    output logic [7:0] o_fb_data,
    output logic       o_fb_dir,
    output logic       o_fb_start,
    input  logic       i_fb_done
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    bus_state_t r_state;
    logic [3:0] r_gap;
    logic       r_pend;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic       r_dir;
    logic       r_start;

    // fb_done only counts while a cycle is actually driven.
    assign o_done     = r_start & i_fb_done;
    assign o_fb_addr  = r_addr;
    assign o_fb_data  = r_data;
    assign o_fb_dir   = r_dir;
    assign o_fb_start = r_start;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= BUS_IDLE;
            r_gap   <= 4'd0;
            r_pend  <= 1'b0;
            r_addr  <= 8'h00;
            r_data  <= 8'h00;
            r_dir   <= 1'b1;
            r_start <= 1'b0;
        end else begin
            case (r_state)
                BUS_IDLE: begin
                    if (i_req) begin
                        r_addr  <= i_addr;
                        r_data  <= i_data;
                        r_dir   <= i_dir;
                        r_start <= 1'b1;
                        r_state <= BUS_ACTIVE;
                    end
                end
                BUS_ACTIVE: begin
                    if (i_fb_done) begin
                        r_start <= 1'b0;
                        r_gap   <= GAP_LOAD;
                        r_state <= BUS_GAP;
                    end
                end
                BUS_GAP: begin
                    // A request landing during the gap is parked and launched as
                    // soon as the last idle cycle has elapsed.
                    if (i_req) begin
                        r_addr <= i_addr;
                        r_data <= i_data;
                        r_dir  <= i_dir;
                        r_pend <= 1'b1;
                    end
                    if (r_gap == 4'd0) begin
                        if (i_req || r_pend) begin
                            r_start <= 1'b1;
                            r_pend  <= 1'b0;
                            r_state <= BUS_ACTIVE;
                        end else begin
                            r_state <= BUS_IDLE;
                        end
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: r_state <= BUS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/flash_cmd_seq.sv
// rtl/flash_cmd_seq.sv - READ/PROGRAM byte command sequencer for the StrataFlash bridge
//
// Purpose : expands a client READ or PROGRAM request into the flash bus-cycle
//           sequence (command writes, data write, status polling, clear status,
//           return to read-array mode) and reports completion and errors.
// Ports   : CLK_50MHZ, RST                      clock, synchronous active-high reset
//           cmd_start/cmd_write/cmd_addr/cmd_wdata  client request (sampled in IDLE)
//           cmd_busy/cmd_done/cmd_rdata/cmd_error   client status and results
//           fb_addr/fb_data/fb_dir/fb_start         bridge drive (fb_dir 1 = read)
//           fb_done/fb_rdata                        bridge completion and read data

module flash_cmd_seq #(
    parameter int POLL_MAX   = 200,
    parameter int GAP_CYCLES = 1
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic [7:0] cmd_rdata,
    output logic       cmd_error,
    output logic [7:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       fb_dir,
    output logic       fb_start,
    input  logic       fb_done,
    input  logic [7:0] fb_rdata
);

    import flash_pkg::*;

    localparam int            PW         = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

    seq_state_t  r_state;
    logic        r_write;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [PW-1:0] r_poll;
    logic        r_err;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [7:0]  r_rdata;
    logic        r_req;
    logic [7:0]  r_req_data;
    logic        r_req_dir;

    logic          w_bus_done;
    logic [PW-1:0] w_poll_next;

    assign w_poll_next = r_poll + PW'(1);

    assign cmd_busy  = r_busy;
    assign cmd_done  = r_done;
    assign cmd_rdata = r_rdata;
    assign cmd_error = r_error;

    flash_bus_cycle #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_bus (
        .i_clk      (CLK_50MHZ),
        .i_rst      (RST),
        .i_req      (r_req),
        .i_addr     (r_addr),
        .i_data     (r_req_data),
        .i_dir      (r_req_dir),
        .o_done     (w_bus_done),
        .o_fb_addr  (fb_addr),
        .o_fb_data  (fb_data),
        .o_fb_dir   (fb_dir),
        .o_fb_start (fb_start),
        .i_fb_done  (fb_done)
    );

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_poll     <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_rdata    <= 8'h00;
            r_req      <= 1'b0;
            r_req_data <= 8'h00;
            r_req_dir  <= 1'b1;
        end else begin
            r_req  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        r_write    <= cmd_write;
                        r_addr     <= cmd_addr;
                        r_wdata    <= cmd_wdata;
                        r_poll     <= '0;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_req      <= 1'b1;
                        r_req_dir  <= 1'b0;
                        r_req_data <= cmd_write ? CMD_PROGRAM : CMD_READ_ARRAY;
                        r_state    <= cmd_write ? ST_W_40 : ST_W_FF;
                    end
                end
                ST_W_FF: begin
                    if (w_bus_done) begin
                        if (r_write) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_error <= r_err;
                            r_state <= ST_DONE;
                        end else begin
                            r_req     <= 1'b1;
                            r_req_dir <= 1'b1;
                            r_state   <= ST_R_DATA;
                        end
                    end
                end
                ST_R_DATA: begin
                    if (w_bus_done) begin
                        r_rdata <= fb_rdata;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_error <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_W_40: begin
                    if (w_bus_done) begin
                        r_req      <= 1'b1;
                        r_req_dir  <= 1'b0;
                        r_req_data <= r_wdata;
                        r_state    <= ST_W_DATA;
                    end
                end
                ST_W_DATA: begin
                    if (w_bus_done) begin
                        r_req     <= 1'b1;
                        r_req_dir <= 1'b1;
                        r_state   <= ST_R_STAT;
                    end
                end
                ST_R_STAT: begin
                    // The device stays in status mode after the program command,
                    // so every poll is a plain read of the same address.
                    if (w_bus_done) begin
                        r_poll <= w_poll_next;
                        r_req  <= 1'b1;
                        if (!fb_rdata[SR_READY]) begin
                            if (w_poll_next < POLL_LIMIT) begin
                                r_req_dir <= 1'b1;
                            end else begin
                                r_err      <= 1'b1;
                                r_req_dir  <= 1'b0;
                                r_req_data <= CMD_CLR_STATUS;
                                r_state    <= ST_W_50;
                            end
                        end else if (sr_failed(fb_rdata)) begin
                            r_err      <= 1'b1;
                            r_req_dir  <= 1'b0;
                            r_req_data <= CMD_CLR_STATUS;
                            r_state    <= ST_W_50;
                        end else begin
                            r_req_dir  <= 1'b0;
                            r_req_data <= CMD_READ_ARRAY;
                            r_state    <= ST_W_FF;
                        end
                    end
                end
                ST_W_50: begin
                    if (w_bus_done) begin
                        r_req      <= 1'b1;
                        r_req_dir  <= 1'b0;
                        r_req_data <= CMD_READ_ARRAY;
                        r_state    <= ST_W_FF;
                    end
                end
                ST_DONE: begin
                    // One dead cycle so a cmd_start coinciding with cmd_done is dropped.
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/flash_cmd_seq.md
Name: flash_cmd_seq

Overview:
- Command sequencer in front of the Flash bridge (fb_start/fb_done, direction_rw handshake).
- Turns single client requests (READ byte, PROGRAM byte) into Intel StrataFlash bus-cycle sequences: command writes, data writes, status-register polling and return to read-array mode.
- Sits between game logic (score save/load) and the bridge.
- Only one bus cycle is outstanding on the bridge at a time.

Parameters:
- POLL_MAX, 200, maximum status reads per PROGRAM before timeout error.
- GAP_CYCLES, 1, idle cycles with fb_start low between consecutive bus cycles (range 1..15).

Ports:
- CLK_50MHZ  in  1  system clock, 50 MHz.
- RST  in  1  synchronous, active-high reset.
- cmd_start  in  1  request strobe; sampled only while cmd_busy=0.
- cmd_write  in  1  1=PROGRAM, 0=READ; captured with cmd_start.
- cmd_addr  in  8  flash byte address; captured with cmd_start.
- cmd_wdata  in  8  program data; captured with cmd_start.
- cmd_busy  out  1  high from the cycle after acceptance until the cycle of cmd_done.
- cmd_done  out  1  one-cycle completion pulse.
- cmd_rdata  out  8  READ result; valid and held from cmd_done until the next acceptance.
- cmd_error  out  1  valid with cmd_done; 1 = status error or poll timeout.
- fb_addr  out  8  address to bridge (addr).
- fb_data  out  8  write data to bridge (data).
- fb_dir  out  1  to bridge direction_rw: 1=read, 0=write.
- fb_start  out  1  bridge trigger, level.
- fb_done  in  1  bridge completion.
- fb_rdata  in  8  byte read by bridge; valid in any cycle with fb_done=1 and fb_dir=1.

Behaviour:
- Reset: all outputs 0, fb_dir=1, state IDLE, counters 0. RST mid-operation aborts at once: fb_start drops the next edge and no cmd_done is issued.
- Bus-cycle primitive (BUS): drive fb_addr/fb_data/fb_dir, then raise fb_start. Hold all four stable until fb_done=1 is sampled. In that cycle capture fb_rdata if reading. Next cycle fb_start=0, held low GAP_CYCLES cycles (GAP state) before the next bus cycle.
- fb_done seen while fb_start=0 is ignored.
- Acceptance: in IDLE with cmd_start=1, capture cmd_write/addr/wdata. cmd_busy=1 from the next cycle. cmd_start while busy is ignored, with no queueing.
- READ sequence:
  - W_FF: write 0xFF (read-array) to cmd_addr.
  - R_DATA: read cmd_addr; cmd_rdata <= fb_rdata.
  - DONE: cmd_error=0.
- PROGRAM sequence:
  - W_40: write 0x40 to cmd_addr.
  - W_DATA: write cmd_wdata to cmd_addr.
  - R_STAT: read status from cmd_addr; poll_cnt+1.
    - If status[7]=0 and poll_cnt<POLL_MAX: GAP then R_STAT.
    - If status[7]=0 and poll_cnt==POLL_MAX: timeout, err=1, go to W_50.
    - If status[7]=1: err = status[4]|status[3]|status[1]. If err go to W_50, else go to W_FF.
  - W_50: write 0x50 (clear status), then W_FF.
  - W_FF: write 0xFF, then DONE.
- After a status read no 0x70 command is needed: the device stays in status mode after a program.
- DONE: cmd_done=1 and cmd_busy=0 in the same cycle; cmd_error reflects err; return to IDLE.
- cmd_start in the DONE cycle is ignored. The earliest acceptance is the cycle after DONE.
- poll_cnt width is clog2(POLL_MAX+1); it is cleared at acceptance.
- cmd_rdata is unchanged by PROGRAM.
- Bus-cycle counts:
  - READ = 2.
  - PROGRAM success = 3 + polls.
  - PROGRAM error = 4 + polls.

Decomposition:
- Shared package flash_pkg holds:
  - command constants CMD_READ_ARRAY=8'hFF, CMD_PROGRAM=8'h40, CMD_CLR_STATUS=8'h50;
  - status bit indices SR_READY=7, SR_PROG_ERR=4, SR_VPP_ERR=3, SR_LOCK_ERR=1;
  - the state enum.
- One natural sub-module: flash_bus_cycle. It implements the BUS+GAP primitive: one request in, done out, owns fb_* and the gap counter. The top-level FSM sequences it.

Test Plan:
- READ: cmd_start, cmd_write=0, cmd_addr=8'h12. Bridge model returns 8'hA5 on the read. Expected: bus writes 0xFF @0x12, then a read @0x12. cmd_done pulses once, cmd_rdata=8'hA5, cmd_error=0. fb_start is low for exactly 1 cycle between the two bus cycles.
- PROGRAM success: addr=8'h30, data=8'h5C. Model returns status 8'h00 twice, then 8'h80. Expected bus trace: W 0x40, W 0x5C, R, R, R, W 0xFF (6 cycles); cmd_error=0.
- PROGRAM status error: model returns 8'h90 on the first poll. Expected: W 0x40, W data, R, W 0x50, W 0xFF; cmd_error=1.
- Poll timeout: POLL_MAX=4, status stuck at 8'h00. Expected: exactly 4 status reads, then W 0x50, W 0xFF; cmd_error=1.
- Busy/ignore: pulse cmd_start again during a PROGRAM and in the cmd_done cycle. Expected: no second transaction; a cmd_start the cycle after cmd_done is accepted.
- Reset mid-op: assert RST while fb_start=1 in W_DATA. Expected: all outputs 0 and fb_dir=1 the next cycle, no cmd_done; a READ issued after reset completes normally.
